// File: rtl/sqrt_sequencer.sv
// Sequencer for the sqrt_add iterative square-root datapath: takes one operand per
// start/busy/done handshake, drives load/start/ctrl/excounter, and registers the result.
module sqrt_sequencer #(
  parameter  int DW   = 16,
  localparam int ITER = DW / 2
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          start_i,
  input  logic          clear_i,
  input  logic [DW-1:0] din_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [DW-1:0] q_out_o,
  output logic [DW-1:0] rem_out_o,
  output logic          dp_load_o,
  output logic          dp_start_o,
  output logic          dp_ctrl_o,
  output logic [DW-1:0] dp_d_o,
  output logic [DW-1:0] dp_excounter_o,
  input  logic [DW-1:0] dp_q_i,
  input  logic [DW-1:0] dp_remainder_i
);

  // state  | meaning
  // IDLE   | waiting for start
  // LOAD   | datapath load, excounter = ITER
  // ITER   | datapath iterating, excounter counts down to 0
  // FINISH | datapath ctrl, results captured on exit
  // DONE   | one-cycle done pulse
  localparam int CW = $clog2(ITER + 1);

  typedef enum logic [4:0] {
    S_IDLE = 5'b00001,
    S_LOAD = 5'b00010,
    S_ITER = 5'b00100,
    S_FIN  = 5'b01000,
    S_DONE = 5'b10000
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   opd_q, opd_d;
  logic [DW-1:0]   q_q, q_d;
  logic [DW-1:0]   rem_q, rem_d;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      opd_q   <= '0;
      q_q     <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opd_q   <= opd_d;
      q_q     <= q_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opd_d   = opd_q;
    q_d     = q_q;
    rem_d   = rem_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start_i) begin
          state_d = S_LOAD;
          opd_d   = din_i;
          cnt_d   = CW'(ITER);
        end
      end
      S_LOAD: begin
        if (clear_i) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          state_d = S_ITER;
          cnt_d   = CW'(ITER - 1);
        end
      end
      S_ITER: begin
        if (clear_i) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = S_FIN;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_FIN: begin
        cnt_d   = '0;
        state_d = S_IDLE;
        if (!clear_i) begin
          state_d = S_DONE;
          q_d     = dp_q_i;
          rem_d   = dp_remainder_i;
        end
      end
      S_DONE: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs decode only registered state, so no input reaches an output combinationally.
  always_comb begin
    busy_o         = (state_q != S_IDLE);
    done_o         = (state_q == S_DONE);
    dp_load_o      = (state_q == S_LOAD);
    dp_start_o     = (state_q == S_ITER);
    dp_ctrl_o      = (state_q == S_FIN);
    dp_excounter_o = {{(DW - CW){1'b0}}, cnt_q};
    dp_d_o         = opd_q;
    q_out_o        = q_q;
    rem_out_o      = rem_q;
  end

endmodule
